// File: rtl/dti_pkg.sv
// Shared DTI definitions: address-width helper, pointer type and level width
// for the default FIFO geometry.
package dti_pkg;

  localparam int unsigned DTI_DEPTH_DEFAULT = 4;

  // Address width for a given depth, never below one bit.
  function automatic int unsigned aw_of(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned DTI_AW      = aw_of(DTI_DEPTH_DEFAULT);
  localparam int unsigned DTI_LEVEL_W = DTI_AW + 1;

  typedef logic [DTI_AW:0] dti_ptr_t;

endpackage

// File: rtl/dti_if.sv
// DTI valid/ready handshake bundle; producer drives data/valid, consumer drives ready.
interface dti #(
  parameter int unsigned W_DATA = 64
);
  logic              valid;
  logic              ready;
  logic [W_DATA-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
  modport master   (output valid, output data, input  ready);
  modport slave    (input  valid, input  data, output ready);
endinterface

// File: rtl/dti_fifo_mem.sv
// DEPTH x W_DATA register array: one synchronous write port, one asynchronous read port.
module dti_fifo_mem #(
  parameter int unsigned W_DATA = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [W_DATA-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [W_DATA-1:0] rdata
);

  logic [W_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dti_fifo.sv
// Show-ahead synchronous elastic buffer between two DTI links.
// Optional embedded protocol assertions: define DTI_FIFO_ASSERT_EN.
module dti_fifo
  import dti_pkg::*;
#(
  parameter int unsigned W_DATA = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dti.consumer                 din,
  dti.producer                 dout,
  output logic [aw_of(DEPTH):0] level
);

  localparam int unsigned AW = aw_of(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // Ready is gated by reset so nothing is accepted while rst is low.
  assign din.ready  = !full && rst;
  assign dout.valid = !empty;

  assign push = din.valid && din.ready;
  assign pop  = dout.valid && dout.ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  dti_fifo_mem #(
    .W_DATA (W_DATA),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din.data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout.data)
  );

`ifdef DTI_FIFO_ASSERT_EN
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full))
    else $error("%m: push while full");
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && empty))
    else $error("%m: pop while empty");
  a_level_range: assert property (@(posedge clk) disable iff (!rst) level <= DEPTH)
    else $error("%m: level exceeds DEPTH");
  a_hold: assert property (@(posedge clk) disable iff (!rst)
                           dout.valid && !dout.ready |=> dout.valid && $stable(dout.data))
    else $error("%m: output not held while stalled");
  a_din_valid_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(din.valid))
    else $error("%m: din.valid unknown");
  a_dout_ready_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(dout.ready))
    else $error("%m: dout.ready unknown");
`else
  // Checks disabled: no assertion logic in this build.
`endif

endmodule

// File: tb/tb_dti_fifo.sv
// Directed bench for dti_fifo (W_DATA=8, DEPTH=4) with a queue scoreboard and occupancy model.
module tb_dti_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic       clk;
  logic       rst;
  logic [2:0] level;

  dti #(.W_DATA(W)) din_if ();
  dti #(.W_DATA(W)) dout_if ();

  dti_fifo #(
    .W_DATA (W),
    .DEPTH  (D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din_if.consumer),
    .dout  (dout_if.producer),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         mlevel = 0;
  bit         known  = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance model over the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bit mpush;
    bit mpop;
    logic [7:0] head;
    din_if.valid  = v;
    din_if.data   = d;
    dout_if.ready = r;
    #1;
    chk("din_ready", {31'b0, din_if.ready}, {31'b0, (rst && (mlevel < int'(D)))});
    if (known) begin
      chk("dout_valid", {31'b0, dout_if.valid}, {31'b0, (mlevel != 0)});
      chk("level", {29'b0, level}, mlevel);
      if (mlevel != 0) chk("head_data", {24'b0, dout_if.data}, {24'b0, exp_q[0]});
    end
    mpush = rst && v && (mlevel < int'(D));
    mpop  = rst && r && (mlevel > 0);
    if (mpop) begin
      head = exp_q.pop_front();
      chk("pop_data", {24'b0, dout_if.data}, {24'b0, head});
    end
    if (mpush) exp_q.push_back(d);
    @(posedge clk);
    if (!rst) begin
      mlevel = 0;
      exp_q.delete();
      known = 1;
    end else begin
      mlevel = mlevel + int'(mpush) - int'(mpop);
    end
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, then release
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Fill with consumer stalled
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h66, 1'b0);

    // Drain from full
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Streaming
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Full with simultaneous push attempt and pop
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    step(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset mid-operation
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Wrap-around: repeated fill/drain
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      step(1'b1, 8'hEE, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    end

    // Random handshake mix
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
